mod_counter: RTL and testbench

//   Parametrised successor to the fixed 4-bit counter: modulo-N up/down counter with

---
 rtl/mod_counter.sv | 85 ++++++++
 tb/tb_mod_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N up/down counter with load, wrap/saturate mode and wrap pulse
//
// Parameters
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset (clears q and wrap)
//   en      in   count enable
//   up      in   1 = increment, 0 = decrement
//   load    in   synchronous parallel load, overrides en
//   d       in   load value (clamped to MODULUS-1)
//   sat     in   1 = saturate at the limit, 0 = wrap modulo MODULUS
//   q       out  current count
//   tc      out  terminal count for the current direction (combinational)
//   wrap    out  registered one-cycle pulse after a wrap

module mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("mod_counter: MODULUS out of range for WIDTH");
    end

    // Largest legal count; fits in WIDTH bits because MODULUS <= 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic at_max;
    logic at_min;

    assign at_max = (q == MAX);
    assign at_min = (q == '0);

    // Not gated by en, so a following stage can use en & tc as its enable.
    assign tc = up ? at_max : at_min;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= (d > MAX) ? MAX : d;
            wrap <= 1'b0;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    q    <= q + 1'b1;
                    wrap <= 1'b0;
                end else if (!sat) begin
                    q    <= '0;
                    wrap <= 1'b1;
                end else begin
                    wrap <= 1'b0;
                end
            end else begin
                if (!at_min) begin
                    q    <= q - 1'b1;
                    wrap <= 1'b0;
                end else if (!sat) begin
                    q    <= MAX;
                    wrap <= 1'b1;
                end else begin
                    wrap <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - randomized and directed self-checking bench for mod_counter
`timescale 1us/1ns

module tb_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] d;
    logic         sat;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;

    // cascade pair, separately reset
    logic         creset;
    logic         cen;
    logic [W-1:0] q1;
    logic [W-1:0] q2;
    logic         tc1;
    logic         tc2;
    logic         wrap1;
    logic         wrap2;
    logic         en2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #10 clk = ~clk;

    mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .d(d), .sat(sat), .q(q), .tc(tc), .wrap(wrap)
    );

    assign en2 = cen & tc1;

    mod_counter #(.WIDTH(W), .MODULUS(M)) c1 (
        .clk(clk), .reset(creset), .en(cen), .up(1'b1), .load(1'b0),
        .d(4'd0), .sat(1'b0), .q(q1), .tc(tc1), .wrap(wrap1)
    );

    mod_counter #(.WIDTH(W), .MODULUS(M)) c2 (
        .clk(clk), .reset(creset), .en(en2), .up(1'b1), .load(1'b0),
        .d(4'd0), .sat(1'b0), .q(q2), .tc(tc2), .wrap(wrap2)
    );

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: the count as a plain integer in 0..M-1.
    int mq;
    int mw;

    function automatic int clamp_load(input int v);
        return (v > M - 1) ? M - 1 : v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq <= 0;
            mw <= 0;
        end else if (load) begin
            mq <= clamp_load(int'(d));
            mw <= 0;
        end else if (en) begin
            if ((mq + (up ? 1 : -1)) inside {[0:M-1]}) begin
                mq <= mq + (up ? 1 : -1);
                mw <= 0;
            end else if (sat) begin
                mw <= 0;
            end else begin
                mq <= (mq + (up ? 1 : -1) + M) % M;
                mw <= 1;
            end
        end else begin
            mw <= 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            check("model_q", int'(q), mq);
            check("model_wrap", int'(wrap), mw);
            check("model_tc", int'(tc), int'(up ? (mq == M - 1) : (mq == 0)));
        end
    end

    // One edge; returns 2us after the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        d    = W'(v);
        tick();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = '0; sat = 1'b0;
        creset = 1'b0; cen = 1'b0;

        #5;
        check("reset_q", int'(q), 0);
        check("reset_wrap", int'(wrap), 0);
        check("reset_tc_down", int'(tc), 1);
        #20 reset = 1'b1;
        @(negedge clk); #2;

        // 1. count to 5, asynchronous reset between edges, resume
        en = 1'b1; up = 1'b1; sat = 1'b0;
        repeat (5) tick();
        check("t1_q5", int'(q), 5);
        #1 reset = 1'b0;
        #1;
        check("t1_async_q", int'(q), 0);
        check("t1_async_wrap", int'(wrap), 0);
        #4 reset = 1'b1;
        tick();
        check("t1_resume1", int'(q), 1);
        tick();
        check("t1_resume2", int'(q), 2);

        // 2. up wrap over 12 edges
        do_load(0);
        check("t2_start", int'(q), 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t2_q", int'(q), (i + 1) % 10);
            check("t2_wrap", int'(wrap), (i == 9) ? 1 : 0);
            check("t2_tc", int'(tc), (((i + 1) % 10) == 9) ? 1 : 0);
        end

        // 3. down wrap, then down saturate
        en = 1'b0;
        do_load(1);
        en = 1'b1; up = 1'b0; sat = 1'b0;
        tick(); check("t3_q0", int'(q), 0); check("t3_w0", int'(wrap), 0);
        tick(); check("t3_q9", int'(q), 9); check("t3_w9", int'(wrap), 1);
        tick(); check("t3_q8", int'(q), 8); check("t3_w8", int'(wrap), 0);
        do_load(1);
        sat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_sat_q", int'(q), 0);
            check("t3_sat_wrap", int'(wrap), 0);
            check("t3_sat_tc", int'(tc), 1);
        end

        // 4. load priority and clamp, then wrap from the clamped value
        sat = 1'b0; up = 1'b1; en = 1'b1;
        do_load(7);
        check("t4_load7", int'(q), 7);
        do_load(13);
        check("t4_clamp", int'(q), 9);
        check("t4_clamp_wrap", int'(wrap), 0);
        tick();
        check("t4_wrap_q", int'(q), 0);
        check("t4_wrap", int'(wrap), 1);

        // 5. enable hold and direction toggling
        en = 1'b0;
        do_load(4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_hold_q", int'(q), 4);
            check("t5_hold_wrap", int'(wrap), 0);
        end
        en = 1'b1;
        up = 1'b1; tick(); check("t5_up5a", int'(q), 5);
        up = 1'b0; tick(); check("t5_dn4a", int'(q), 4);
        up = 1'b1; tick(); check("t5_up5b", int'(q), 5);
        up = 1'b0; tick(); check("t5_dn4b", int'(q), 4);
        en = 1'b0;
        do_load(9);
        up = 1'b1; #1 check("t5_tc_up_at9", int'(tc), 1);
        up = 1'b0; #1 check("t5_tc_dn_at9", int'(tc), 0);
        do_load(0);
        up = 1'b0; #1 check("t5_tc_dn_at0", int'(tc), 1);
        up = 1'b1; #1 check("t5_tc_up_at0", int'(tc), 0);

        // randomized run checked by the model every cycle
        for (int i = 0; i < 2000; i++) begin
            load = ($urandom_range(7) == 0);
            d    = W'($urandom_range(15));
            en   = ($urandom_range(3) != 0);
            up   = $urandom_range(1) == 1;
            sat  = ($urandom_range(3) == 0);
            tick();
        end
        load = 1'b0; en = 1'b0;

        // 6. cascade of two decades for 25 edges from reset
        #1 creset = 1'b1;
        cen = 1'b1;
        repeat (25) tick();
        check("t6_q1", int'(q1), 5);
        check("t6_q2", int'(q2), 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
